// File: rtl/laser500_pkg.sv
// Shared types and constants for the Laser 500 cassette path.
package laser500_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HIGH,
    LOW,
    DONE
  } cas_state_t;

  localparam int unsigned F14M_HZ = 14_778_730;
  // 250 us rounded to the nearest F14M tick; a '1' half-cycle is twice that.
  localparam int unsigned T0_HALF_DEF = (F14M_HZ + 2000) / 4000;
  localparam int unsigned T1_HALF_DEF = 2 * T0_HALF_DEF;

endpackage

// File: rtl/cas_player_if.sv
// Byte-fetch handshake between the cassette player and the SDRAM arbiter.
interface cas_player_if #(
  parameter int ADDR_W = 25
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic [7:0]        rd_data;

  modport master (output rd_req, rd_addr, input rd_ack, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_ack, rd_data);

endinterface

// File: rtl/cas_halfcycle_timer.sv
// Down-counting half-cycle timer: loads N-1, expires on the N-th enabled tick.
module cas_halfcycle_timer #(
  parameter int CNT_W = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/cas_player.sv
// Tape-image playback from SDRAM into the VTL CASIN line, MSB first, one-byte prefetch.
// Optional feature: define CAS_PLAYER_PAUSE_EN to add the pause input.
module cas_player
  import laser500_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int T0_HALF = int'(T0_HALF_DEF),
  parameter int T1_HALF = int'(T1_HALF_DEF),
  parameter int CNT_W   = 13
) (
  input  logic              F14M,
  input  logic              RESET,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base,
  input  logic [23:0]       len,
  cas_player_if.master      rd,
  output logic              casin,
  output logic              busy,
  output logic              done,
  output logic              underrun
`ifdef CAS_PLAYER_PAUSE_EN
  ,
  input  logic              pause
`endif
);

  cas_state_t        state_q, state_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0]       rem_q, rem_d;
  logic              und_q, und_d;
  logic              zdone_q, zdone_d;

  logic              run_en;
  logic              ack_ok;
  logic              byte_avail;
  logic [7:0]        byte_val;
  logic              load_byte;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_en;
  logic              tmr_exp;

  function automatic logic [CNT_W-1:0] half_m1(input logic bit_v);
    return bit_v ? CNT_W'(T1_HALF - 1) : CNT_W'(T0_HALF - 1);
  endfunction

`ifdef CAS_PLAYER_PAUSE_EN
  assign run_en = ~pause;
`else
  assign run_en = 1'b1;
`endif

  // Acks are only honoured against our own outstanding request.
  assign ack_ok     = rd.rd_ack & req_q;
  assign byte_avail = buf_full_q | ack_ok;
  assign byte_val   = buf_full_q ? buf_q : rd.rd_data;
  assign tmr_en     = run_en && ((state_q == HIGH) || (state_q == LOW));

  cas_halfcycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i     (F14M),
    .rst_i     (RESET),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .en_i      (tmr_en),
    .expire_o  (tmr_exp)
  );

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    req_d      = req_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    und_d      = und_q;
    zdone_d    = 1'b0;
    load_byte  = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    if (ack_ok) begin
      req_d  = 1'b0;
      addr_d = addr_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          und_d = 1'b0;
          if (len != '0) begin
            state_d = FETCH;
            addr_d  = base;
            rem_d   = len;
            req_d   = 1'b1;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      FETCH: load_byte = byte_avail && run_en;
      HIGH: begin
        if (tmr_exp) begin
          state_d  = LOW;
          tmr_load = 1'b1;
          tmr_val  = half_m1(sh_q[7]);
        end
      end
      LOW: begin
        if (tmr_exp) begin
          if (bit_q != 3'd0) begin
            state_d  = HIGH;
            sh_d     = {sh_q[6:0], 1'b0};
            bit_d    = bit_q - 3'd1;
            tmr_load = 1'b1;
            tmr_val  = half_m1(sh_q[6]);
          end else if (rem_q == '0) begin
            state_d = DONE;
          end else if (byte_avail) begin
            load_byte = 1'b1;
          end else begin
            state_d = FETCH;
            und_d   = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The next byte's fetch goes out the moment this one enters the shifter.
    if (load_byte) begin
      state_d    = HIGH;
      sh_d       = byte_val;
      bit_d      = 3'd7;
      rem_d      = rem_q - 24'd1;
      req_d      = (rem_q > 24'd1);
      buf_full_d = 1'b0;
      tmr_load   = 1'b1;
      tmr_val    = half_m1(byte_val[7]);
    end else if (ack_ok) begin
      buf_d      = rd.rd_data;
      buf_full_d = 1'b1;
    end

    if (stop) begin
      state_d    = IDLE;
      req_d      = 1'b0;
      buf_full_d = 1'b0;
      zdone_d    = 1'b0;
    end
  end

  always_ff @(posedge F14M) begin
    if (RESET) begin
      state_q    <= IDLE;
      bit_q      <= 3'd0;
      buf_full_q <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      und_q      <= 1'b0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      buf_full_q <= buf_full_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      und_q      <= und_d;
      zdone_q    <= zdone_d;
    end
  end

  always_ff @(posedge F14M) begin
    sh_q  <= sh_d;
    buf_q <= buf_d;
  end

  assign rd.rd_req  = req_q;
  assign rd.rd_addr = addr_q;
  assign casin      = (state_q == HIGH);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) | zdone_q;
  assign underrun   = und_q;

endmodule
